// File: rtl/pbi_spi_shifter_pkg.sv
// Shared definitions for the PBI byte-wide SPI master: state encodings,
// default idle byte, register offsets and status byte layout.
package pbi_spi_shifter_pkg;

  localparam int unsigned DIV_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;

  localparam logic [BYTE_W-1:0] IDLE_TX_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  // Register offsets seen by the decoder and read mux
  typedef enum logic [15:0] {
    REG_STATUS = 16'hD1FC,
    REG_SELECT = 16'hD1FD,
    REG_DATA   = 16'hD1FE
  } reg_addr_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       overrun;
    logic [4:0] rsvd;
  } status_t;

  function automatic status_t make_status(input logic busy, input logic done,
                                          input logic overrun);
    status_t s;
    s.busy    = busy;
    s.done    = done;
    s.overrun = overrun;
    s.rsvd    = '0;
    return s;
  endfunction

endpackage

// File: rtl/pbi_spi_shifter_tick.sv
// Half-period divider: counts 0..HALF_DIV while enabled and pulses tick_c
// on the last count; restart or disable returns the count to zero.
module pbi_spi_shifter_tick
  import pbi_spi_shifter_pkg::*;
#(
  parameter int unsigned HALF_DIV = 0
) (
  input  logic Phi2,
  input  logic Reset,
  input  logic en,
  input  logic restart,
  output logic tick_c
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(HALF_DIV);

  logic [DIV_W-1:0] cnt;

  assign tick_c = en && (cnt == LAST);

  // Count wraps to zero on every tick, which coincides with each state change
  always_ff @(negedge Phi2) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (restart || !en || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pbi_spi_shifter.sv
// Byte-wide SPI mode-0 master for the PBI board: shifts 8 bits MSB-first,
// captures SpiDI, and keeps Busy/Done/Overrun for the status read mux.
module pbi_spi_shifter
  import pbi_spi_shifter_pkg::*;
#(
  parameter int unsigned       HALF_DIV = 0,
  parameter logic [BYTE_W-1:0] IDLE_TX  = IDLE_TX_DEFAULT
) (
  input  logic              Phi2,
  input  logic              Reset,
  input  logic              WrStb,
  input  logic [BYTE_W-1:0] WrData,
  input  logic              RdStb,
  input  logic              CsWrStb,
  input  logic              CsWrData,
  input  logic              AutoRead,
  input  logic              SpiDI,
  output logic              SpiDO,
  output logic              SpiCK,
  output logic              SpiCS,
  output logic [BYTE_W-1:0] RxData,
  output logic              Busy,
  output logic              Done,
  output logic              Overrun
);

  state_t            state;
  logic [BYTE_W-2:0] sh;
  logic              din_q;
  logic [BIT_W-1:0]  bitcnt;
  logic              tick_c;
  logic              start_c;
  logic [BYTE_W-1:0] start_byte_c;

  assign start_c      = (state == ST_IDLE) && !Busy && (WrStb || (RdStb && AutoRead));
  assign start_byte_c = WrStb ? WrData : IDLE_TX;

  pbi_spi_shifter_tick #(
    .HALF_DIV(HALF_DIV)
  ) u_tick (
    .Phi2   (Phi2),
    .Reset  (Reset),
    .en     (state != ST_IDLE),
    .restart(start_c),
    .tick_c (tick_c)
  );

  // sh holds the not-yet-sent tx bits on the MSB side and collects rx bits
  // on the LSB side; the bit sampled at the end of LO waits in din_q until
  // the shift at the end of HI.
  always_ff @(negedge Phi2) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      sh      <= '0;
      din_q   <= 1'b0;
      bitcnt  <= '0;
      Busy    <= 1'b0;
      SpiCK   <= 1'b0;
      SpiDO   <= 1'b0;
      SpiCS   <= 1'b0;
      RxData  <= '0;
      Done    <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      if (CsWrStb) begin
        SpiCS <= CsWrData;
      end
      if (CsWrStb) begin
        Overrun <= 1'b0;
      end else if (WrStb && Busy) begin
        Overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          SpiCK <= 1'b0;
          if (WrStb || RdStb) begin
            Done <= 1'b0;
          end
          if (start_c) begin
            sh     <= start_byte_c[BYTE_W-2:0];
            SpiDO  <= start_byte_c[BYTE_W-1];
            bitcnt <= BIT_W'(BYTE_W - 1);
            Busy   <= 1'b1;
            state  <= ST_LO;
          end
        end

        ST_LO: begin
          if (tick_c) begin
            SpiCK <= 1'b1;
            din_q <= SpiDI;
            state <= ST_HI;
          end
        end

        ST_HI: begin
          if (tick_c) begin
            SpiCK <= 1'b0;
            if (bitcnt != '0) begin
              sh     <= {sh[BYTE_W-3:0], din_q};
              SpiDO  <= sh[BYTE_W-2];
              bitcnt <= bitcnt - BIT_W'(1);
              state  <= ST_LO;
            end else begin
              RxData <= {sh, din_q};
              Busy   <= 1'b0;
              Done   <= 1'b1;
              SpiDO  <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pbi_spi_shifter.sv
// Self-checking bench for pbi_spi_shifter: table vectors, randomized transfers
// against a byte-level model, and hand-written strobe corner cases.
module tb_pbi_spi_shifter;

  logic       Phi2 = 1'b1;
  logic       Reset = 1'b0;
  logic       WrStb = 1'b0;
  logic [7:0] WrData = 8'h00;
  logic       RdStb = 1'b0;
  logic       CsWrStb = 1'b0;
  logic       CsWrData = 1'b0;
  logic       AutoRead = 1'b0;
  logic       di = 1'b0;
  logic       loopback = 1'b0;
  logic       sel = 1'b0;

  logic       do0, ck0, cs0, busy0, done0, ovr0, di0;
  logic [7:0] rx0;
  logic       do3, ck3, cs3, busy3, done3, ovr3;
  logic [7:0] rx3;

  logic       do_w, ck_w, cs_w, busy_w, done_w, ovr_w;
  logic [7:0] rx_w;

  int checks = 0;
  int errors = 0;

  always #5 Phi2 = ~Phi2;

  assign di0    = loopback ? do0 : di;
  assign do_w   = sel ? do3   : do0;
  assign ck_w   = sel ? ck3   : ck0;
  assign cs_w   = sel ? cs3   : cs0;
  assign busy_w = sel ? busy3 : busy0;
  assign done_w = sel ? done3 : done0;
  assign ovr_w  = sel ? ovr3  : ovr0;
  assign rx_w   = sel ? rx3   : rx0;

  pbi_spi_shifter #(.HALF_DIV(0)) dut0 (
    .Phi2(Phi2), .Reset(Reset), .WrStb(WrStb), .WrData(WrData), .RdStb(RdStb),
    .CsWrStb(CsWrStb), .CsWrData(CsWrData), .AutoRead(AutoRead), .SpiDI(di0),
    .SpiDO(do0), .SpiCK(ck0), .SpiCS(cs0), .RxData(rx0), .Busy(busy0),
    .Done(done0), .Overrun(ovr0)
  );

  pbi_spi_shifter #(.HALF_DIV(3)) dut3 (
    .Phi2(Phi2), .Reset(Reset), .WrStb(WrStb), .WrData(WrData), .RdStb(RdStb),
    .CsWrStb(CsWrStb), .CsWrData(CsWrData), .AutoRead(AutoRead), .SpiDI(di),
    .SpiDO(do3), .SpiCK(ck3), .SpiCS(cs3), .RxData(rx3), .Busy(busy3),
    .Done(done3), .Overrun(ovr3)
  );

  typedef struct {
    bit         s;
    bit         loop;
    bit         rd;
    logic [7:0] tx;
    logic [7:0] rx;
    int         exp_busy;
    int         exp_run;
    logic [7:0] exp_do;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0; WrStb = 1'b0; RdStb = 1'b0; CsWrStb = 1'b0;
    @(posedge Phi2);
    Reset = 1'b1;
  endtask

  // Starts a transfer at the current posedge, follows it until Busy drops and
  // records what the device saw; mid_kind 1/2 fires WrStb/RdStb at busy cycle mid_at.
  task automatic xfer(input bit s, input logic [7:0] tx_in, input bit use_rd,
                      input logic [7:0] rx_in, input int mid_at, input int mid_kind,
                      output int nbusy, output logic [7:0] do_seen, output int nbits,
                      output int minrun, output int maxrun);
    int   k;
    int   run;
    logic prev;
    sel = s;
    di = rx_in[7];
    if (use_rd) RdStb = 1'b1;
    else begin WrData = tx_in; WrStb = 1'b1; end
    k = 0; nbusy = 0; run = 0; prev = 1'b0;
    minrun = 999; maxrun = 0; do_seen = 8'h00;
    for (int c = 0; c < 400; c++) begin
      @(posedge Phi2);
      WrStb = 1'b0; RdStb = 1'b0;
      if (!busy_w) break;
      nbusy++;
      if (ck_w != prev && run > 0) begin
        if (run < minrun) minrun = run;
        if (run > maxrun) maxrun = run;
        run = 0;
      end
      run++;
      if (ck_w && !prev) begin
        do_seen = {do_seen[6:0], do_w};
        k++;
        if (k < 8) di = rx_in[7-k];
      end
      prev = ck_w;
      if (c == mid_at) begin
        if (mid_kind == 1) begin WrData = 8'h80; WrStb = 1'b1; end
        else if (mid_kind == 2) RdStb = 1'b1;
      end
    end
    if (run > 0) begin
      if (run < minrun) minrun = run;
      if (run > maxrun) maxrun = run;
    end
    nbits = k;
  endtask

  initial begin
    int         nb, nbits, mn, mx;
    logic [7:0] dseen;
    logic [7:0] tx, rx, exp_do;
    bit         rd;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 16, 1, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h3C, 8'hFF, 64, 4, 8'h3C, 8'hFF};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 16, 1, 8'h00, 8'hFF};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 16, 1, 8'hFF, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h81, 8'h7E, 64, 4, 8'h81, 8'h7E};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 8'hC3, 8'h5A, 16, 1, 8'hC3, 8'h5A};

    repeat (3) @(posedge Phi2);
    check("reset_state", {busy0, ck0, do0, cs0, done0, ovr0, rx0}, 32'h0);
    check("reset_state_div3", {busy3, ck3, do3, cs3, done3, ovr3, rx3}, 32'h0);
    Reset = 1'b1;

    // Table vectors
    foreach (vecs[i]) begin
      do_reset();
      loopback = vecs[i].loop;
      AutoRead = vecs[i].rd;
      xfer(vecs[i].s, vecs[i].tx, vecs[i].rd, vecs[i].rx, -1, 0, nb, dseen, nbits, mn, mx);
      check($sformatf("vec%0d_busy_cycles", i), nb, vecs[i].exp_busy);
      check($sformatf("vec%0d_bits", i), nbits, 8);
      check($sformatf("vec%0d_spido", i), dseen, vecs[i].exp_do);
      check($sformatf("vec%0d_rxdata", i), rx_w, vecs[i].exp_rx);
      check($sformatf("vec%0d_done", i), done_w, 1);
      check($sformatf("vec%0d_ck_min", i), mn, vecs[i].exp_run);
      check($sformatf("vec%0d_ck_max", i), mx, vecs[i].exp_run);
    end

    // Randomized back-to-back transfers on the HALF_DIV=0 instance
    do_reset();
    loopback = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tx = 8'($urandom);
      rx = 8'($urandom);
      rd = 1'($urandom_range(0, 1));
      AutoRead = rd;
      exp_do = rd ? 8'hFF : tx;
      xfer(1'b0, tx, rd, rx, -1, 0, nb, dseen, nbits, mn, mx);
      check($sformatf("rand%0d_busy_cycles", i), nb, 16 * (0 + 1));
      check($sformatf("rand%0d_spido", i), dseen, exp_do);
      check($sformatf("rand%0d_rxdata", i), rx0, rx);
      check($sformatf("rand%0d_done", i), done0, 1);
    end

    // Write during a transfer is dropped and flagged; select write clears the flag
    do_reset();
    loopback = 1'b1; AutoRead = 1'b0;
    xfer(1'b0, 8'h01, 1'b0, 8'h00, 4, 1, nb, dseen, nbits, mn, mx);
    check("ovr_busy_cycles", nb, 16);
    check("ovr_rxdata_first_byte", rx0, 8'h01);
    check("ovr_flag_set", ovr0, 1);
    CsWrData = 1'b1; CsWrStb = 1'b1;
    @(posedge Phi2);
    CsWrStb = 1'b0;
    check("ovr_cleared_by_cs", ovr0, 0);
    check("cs_asserted", cs0, 1);
    check("cs_no_start", busy0, 0);

    // Auto-read: read during a transfer neither restarts nor queues
    do_reset();
    loopback = 1'b0; AutoRead = 1'b1;
    xfer(1'b0, 8'h00, 1'b1, 8'h00, 6, 2, nb, dseen, nbits, mn, mx);
    check("auto_busy_cycles", nb, 16);
    check("auto_spido_ff", dseen, 8'hFF);
    check("auto_rxdata", rx0, 8'h00);
    @(posedge Phi2);
    check("auto_no_restart", busy0, 0);
    check("auto_done_kept", done0, 1);
    AutoRead = 1'b0; RdStb = 1'b1;
    @(posedge Phi2);
    RdStb = 1'b0;
    check("rd_idle_clears_done", done0, 0);
    check("rd_idle_no_start", busy0, 0);

    // Reset in the middle of a transfer abandons it
    do_reset();
    loopback = 1'b1;
    xfer(1'b0, 8'hC3, 1'b0, 8'h00, -1, 0, nb, dseen, nbits, mn, mx);
    check("pre_abort_rxdata", rx0, 8'hC3);
    CsWrData = 1'b1; CsWrStb = 1'b1;
    WrData = 8'h5A; WrStb = 1'b1;
    @(posedge Phi2);
    CsWrStb = 1'b0; WrStb = 1'b0;
    repeat (8) @(posedge Phi2);
    check("pre_abort_busy", {busy0, cs0}, 2'b11);
    Reset = 1'b0;
    @(posedge Phi2);
    Reset = 1'b1;
    check("abort_state", {busy0, ck0, do0, cs0, done0, ovr0, rx0}, 32'h0);
    @(posedge Phi2);
    check("abort_stays_idle", {busy0, rx0}, 32'h0);

    // Strobe in the completing cycle is not a start; one cycle later it is
    do_reset();
    loopback = 1'b1;
    xfer(1'b0, 8'h96, 1'b0, 8'h00, 15, 1, nb, dseen, nbits, mn, mx);
    check("edge_first_busy_cycles", nb, 16);
    check("edge_no_start", busy0, 0);
    check("edge_overrun", ovr0, 1);
    check("edge_first_rxdata", rx0, 8'h96);
    xfer(1'b0, 8'h5A, 1'b0, 8'h00, -1, 0, nb, dseen, nbits, mn, mx);
    check("edge_second_busy_cycles", nb, 16);
    check("edge_second_rxdata", rx0, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
